// File: rtl/dmem_bus_pkg.sv
// Shared definitions for the data-memory read bus: FSM encoding, default
// widths and requester (owner) encoding.
package dmem_bus_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

    // Gray-ordered so each legal transition flips a single bit.
    localparam logic [1:0] ST_IDLE         = 2'b00;
    localparam logic [1:0] ST_WAIT_READY   = 2'b01;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'b11;
    localparam logic [1:0] ST_DONE         = 2'b10;

    typedef enum logic [1:0] {
        IDLE         = ST_IDLE,
        WAIT_READY   = ST_WAIT_READY,
        WAIT_RELEASE = ST_WAIT_RELEASE,
        DONE         = ST_DONE
    } state_t;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. Purely combinational; the caller owns the
// last_gnt register so the same arbiter can serve other bus masters.
module rr_arb2
    import dmem_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // A lone requester wins; on a tie the one not served last wins.
    always_comb begin
        gnt_valid = |req;
        gnt_id    = OWNER_M0;
        if (req == 2'b11) begin
            gnt_id = ~last_gnt;
        end else if (req[1]) begin
            gnt_id = OWNER_M1;
        end
    end

endmodule

// File: rtl/dmem_read_master.sv
// Data-memory read master: arbitrates two requesters and runs the four-phase
// Read/Ready handshake with a per-phase timeout.
//
// state        | meaning
// IDLE         | no transfer; arbitrate and latch the owner's address
// WAIT_READY   | bus_read high, waiting for the memory to raise Ready
// WAIT_RELEASE | bus_read low, waiting for the memory to drop Ready
// DONE         | owner's done pulse is visible; update round-robin history
module dmem_read_master
    import dmem_bus_pkg::*;
#(
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_done,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_done,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              bus_read,
    output logic [ADDR_W-1:0] bus_address,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_data_in,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    logic              owner;
    logic              last_gnt;
    logic              err_flag;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt;

    logic              gnt_valid;
    logic              gnt_id;
    logic              rel_timeout;
    logic              fin_err;
    logic [DATA_W-1:0] fin_data;

    rr_arb2 u_arb (
        .req       ({m1_req, m0_req}),
        .last_gnt  (last_gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Final status handed to the owner when leaving WAIT_RELEASE; a release
    // timeout marks the transfer as failed even if Ready was seen earlier.
    always_comb begin
        rel_timeout = bus_ready && (cnt == CNT_LAST);
        fin_err     = err_flag | rel_timeout;
        fin_data    = fin_err ? '0 : data_q;
    end

    // Handshake sequencer with registered bus and requester outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= OWNER_M0;
            last_gnt    <= OWNER_M1;
            err_flag    <= 1'b0;
            data_q      <= '0;
            cnt         <= '0;
            bus_read    <= 1'b0;
            bus_address <= '0;
            busy        <= 1'b0;
            m0_done     <= 1'b0;
            m0_err      <= 1'b0;
            m0_rdata    <= '0;
            m1_done     <= 1'b0;
            m1_err      <= 1'b0;
            m1_rdata    <= '0;
        end else begin
            m0_done <= 1'b0;
            m1_done <= 1'b0;
            case (state)
                IDLE: begin
                    // A stale Ready from the memory is deliberately ignored here.
                    if (gnt_valid) begin
                        owner       <= gnt_id;
                        bus_address <= (gnt_id == OWNER_M1) ? m1_addr : m0_addr;
                        bus_read    <= 1'b1;
                        busy        <= 1'b1;
                        err_flag    <= 1'b0;
                        cnt         <= '0;
                        state       <= WAIT_READY;
                    end
                end
                WAIT_READY: begin
                    if (bus_ready) begin
                        data_q   <= bus_data_in;
                        bus_read <= 1'b0;
                        cnt      <= '0;
                        state    <= WAIT_RELEASE;
                    end else if (cnt == CNT_LAST) begin
                        bus_read <= 1'b0;
                        err_flag <= 1'b1;
                        cnt      <= '0;
                        state    <= WAIT_RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_RELEASE: begin
                    if (!bus_ready || rel_timeout) begin
                        // Done is raised on entry so it is high exactly while in DONE.
                        if (owner == OWNER_M1) begin
                            m1_done  <= 1'b1;
                            m1_err   <= fin_err;
                            m1_rdata <= fin_data;
                        end else begin
                            m0_done  <= 1'b1;
                            m0_err   <= fin_err;
                            m0_rdata <= fin_data;
                        end
                        err_flag <= fin_err;
                        cnt      <= '0;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    last_gnt <= owner;
                    err_flag <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus_read <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_read_master.sv
// Scoreboard bench for dmem_read_master: directed requests push expected
// completions; an independent monitor pops and compares on every done pulse.
module tb_dmem_read_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          m0_req = 1'b0, m1_req = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic          m0_done, m0_err, m1_done, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          bus_read, busy;
    logic [AW-1:0] bus_address;
    logic          bus_ready = 1'b0;
    logic [DW-1:0] bus_data_in = '0;

    dmem_read_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .m0_req      (m0_req),
        .m0_addr     (m0_addr),
        .m0_done     (m0_done),
        .m0_err      (m0_err),
        .m0_rdata    (m0_rdata),
        .m1_req      (m1_req),
        .m1_addr     (m1_addr),
        .m1_done     (m1_done),
        .m1_err      (m1_err),
        .m1_rdata    (m1_rdata),
        .bus_read    (bus_read),
        .bus_address (bus_address),
        .bus_ready   (bus_ready),
        .bus_data_in (bus_data_in),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          port;
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    int            errors = 0;
    int            checks = 0;
    int            done_cnt = 0;
    int            rem0 = 0, rem1 = 0;
    int            mem_hold = 0;
    bit            mem_never = 1'b0;
    bit            chk_release = 1'b0;
    int            last_rd_len = 0;
    logic [DW-1:0] model0 = '0, model1 = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_tx(input logic p, input logic e, input logic [DW-1:0] d);
        exp_t x;
        x.port = p;
        x.err  = e;
        x.data = d;
        sb.push_back(x);
    endtask

    // Memory model: Ready two cycles after Read, data = address + 6,
    // Ready held mem_hold extra cycles after Read falls.
    initial begin
        int lat;
        int hold;
        lat  = 0;
        hold = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                bus_ready = 1'b0;
                lat  = 0;
                hold = 0;
            end else if (bus_read && !bus_ready) begin
                lat++;
                if (!mem_never && lat >= 2) begin
                    bus_ready   = 1'b1;
                    bus_data_in = bus_address + 32'd6;
                end
            end else if (!bus_read && bus_ready) begin
                if (hold >= mem_hold) begin
                    bus_ready = 1'b0;
                    hold = 0;
                    lat  = 0;
                end else begin
                    hold++;
                end
            end else if (!bus_read) begin
                lat = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on each done pulse and checks bus rules.
    initial begin
        exp_t e;
        logic rd_prev;
        logic rdy_d1, rdy_d2;
        int   rd_len;
        rd_prev = 1'b0;
        rdy_d1  = 1'b0;
        rdy_d2  = 1'b0;
        rd_len  = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                model0  = '0;
                model1  = '0;
                rd_prev = 1'b0;
                rd_len  = 0;
            end else begin
                if (bus_read) begin
                    if (!rd_prev) check("read_rise_vs_stale_ready", bus_ready, 0);
                    rd_len++;
                end else if (rd_prev) begin
                    last_rd_len = rd_len;
                    rd_len = 0;
                end
                rd_prev = bus_read;
                if (m0_done && m1_done) check("both_done", 1, 0);
                if (m0_done || m1_done) begin
                    done_cnt++;
                    if (sb.size() == 0) begin
                        check("unexpected_done", {m1_done, m0_done}, 0);
                    end else begin
                        e = sb.pop_front();
                        check("done_port", m1_done, e.port);
                        if (m1_done) begin
                            check("m1_err", m1_err, e.err);
                            check("m1_rdata", m1_rdata, e.data);
                            check("m0_rdata_held", m0_rdata, model0);
                            model1 = e.data;
                        end else begin
                            check("m0_err", m0_err, e.err);
                            check("m0_rdata", m0_rdata, e.data);
                            check("m1_rdata_held", m1_rdata, model1);
                            model0 = e.data;
                        end
                        if (chk_release) check("done_after_ready_fall", {rdy_d2, rdy_d1}, 2'b10);
                    end
                end
            end
            rdy_d2 = rdy_d1;
            rdy_d1 = bus_ready;
        end
    end

    // Wait until every outstanding request completes, dropping each req on its last done.
    task automatic wait_all(input int budget);
        int n;
        n = 0;
        while ((rem0 > 0 || rem1 > 0) && n < budget) begin
            @(negedge clk);
            n++;
            if (m0_done && rem0 > 0) begin
                rem0--;
                if (rem0 == 0) m0_req = 1'b0;
            end
            if (m1_done && rem1 > 0) begin
                rem1--;
                if (rem1 == 0) m1_req = 1'b0;
            end
        end
        if (rem0 > 0 || rem1 > 0) begin
            check("completion_timeout", rem0 + rem1, 0);
            rem0 = 0;
            rem1 = 0;
            m0_req = 1'b0;
            m1_req = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        int n;
        int dc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bus_read", bus_read, 0);
        check("rst_bus_address", bus_address, 0);
        check("rst_busy", busy, 0);
        check("rst_m0_outs", {m0_done, m0_err, m0_rdata}, 0);
        check("rst_m1_outs", {m1_done, m1_err, m1_rdata}, 0);
        reset = 1'b0;

        // Single read from m0.
        m0_addr = 32'h100;
        expect_tx(1'b0, 1'b0, 32'h106);
        rem0 = 1;
        m0_req = 1'b1;
        wait_all(50);
        repeat (5) @(negedge clk);
        check("single_done_once", done_cnt, 1);
        check("single_m1_untouched", {m1_done, m1_err, m1_rdata}, 0);

        // Simultaneous requests right after reset: m0 wins the first tie.
        do_reset();
        m0_addr = 32'h10;
        m1_addr = 32'h20;
        expect_tx(1'b0, 1'b0, 32'h16);
        expect_tx(1'b1, 1'b0, 32'h26);
        rem0 = 1;
        rem1 = 1;
        m0_req = 1'b1;
        m1_req = 1'b1;
        wait_all(100);

        // Fairness: both held for four transfers; m1 was served last.
        @(negedge clk);
        m0_addr = 32'h30;
        m1_addr = 32'h40;
        expect_tx(1'b0, 1'b0, 32'h36);
        expect_tx(1'b1, 1'b0, 32'h46);
        expect_tx(1'b0, 1'b0, 32'h36);
        expect_tx(1'b1, 1'b0, 32'h46);
        rem0 = 2;
        rem1 = 2;
        m0_req = 1'b1;
        m1_req = 1'b1;
        wait_all(200);

        // Slow release: Ready held 5 cycles after Read falls.
        @(negedge clk);
        mem_hold = 5;
        chk_release = 1'b1;
        m1_addr = 32'h55;
        expect_tx(1'b1, 1'b0, 32'h5B);
        rem1 = 1;
        m1_req = 1'b1;
        wait_all(100);
        chk_release = 1'b0;
        mem_hold = 0;

        // Timeout: memory never answers.
        @(negedge clk);
        mem_never = 1'b1;
        m0_addr = 32'h200;
        expect_tx(1'b0, 1'b1, 32'h0);
        rem0 = 1;
        m0_req = 1'b1;
        wait_all(100);
        check("timeout_read_len", last_rd_len, TO);
        repeat (2) @(negedge clk);
        check("timeout_back_idle", {busy, bus_read}, 0);

        // Reset in WAIT_READY.
        m1_addr = 32'h300;
        m1_req = 1'b1;
        n = 0;
        while (!bus_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_read_started", bus_read, 1);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_bus_read", bus_read, 0);
        check("mid_rst_busy", busy, 0);
        m1_req = 1'b0;
        dc = done_cnt;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mem_never = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_rst_no_done", done_cnt, dc);

        m1_addr = 32'h310;
        expect_tx(1'b1, 1'b0, 32'h316);
        rem1 = 1;
        m1_req = 1'b1;
        wait_all(50);
        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        check("total_dones", done_cnt, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
